// File: rtl/param_load_ctrl_pkg.sv
// Shared types and constants for the CIM parameter loader.
// PARAM_LOAD_TIMEOUT_EN (when defined) enables the read watchdog in param_load_ctrl.
package param_load_ctrl_pkg;

  localparam int N              = 22;   // bus word, Q10 fixed point
  localparam int Q              = 10;
  localparam int N_STORAGE      = 16;   // external memory word
  localparam int NUM_CIMS       = 64;
  localparam int PARAMS_PER_CIM = 528;
  localparam int NUM_PARAMS     = NUM_CIMS * PARAMS_PER_CIM;
  localparam int TIMEOUT_CYCLES = 1024;

  // clog2 that never collapses to a zero-width vector
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

  localparam int ADDR_W = clog2_min1(NUM_PARAMS);
  localparam int CIM_W  = clog2_min1(NUM_CIMS);
  localparam int WORD_W = clog2_min1(PARAMS_PER_CIM);

  typedef enum logic [1:0] {
    NOP                   = 2'd0,
    PARAM_STREAM_START_OP = 2'd1,
    PARAM_STREAM_OP       = 2'd2,
    BUS_RESERVED_OP       = 2'd3
  } BusOp_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_CIMS = 3'd1,
    S_START_CIM = 3'd2,
    S_REQ       = 3'd3,
    S_WAIT_DATA = 3'd4,
    S_SEND      = 3'd5,
    S_DONE      = 3'd6
  } plc_state_t;

endpackage

// File: rtl/param_load_ctrl_counter.sv
// Team counter IP: synchronous clear (priority) and increment, async active-high reset.
module counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)      count_d = '0;
    else if (inc_i) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/param_load_ctrl.sv
// One-shot parameter loader: external memory -> sign-extend -> CIM bus broadcast.
// Optional read watchdog compiled in with `define PARAM_LOAD_TIMEOUT_EN.
module param_load_ctrl
  import param_load_ctrl_pkg::*;
#(
  parameter int NUM_CIMS_P       = NUM_CIMS,
  parameter int PARAMS_PER_CIM_P = PARAMS_PER_CIM,
  parameter int TIMEOUT_CYCLES_P = TIMEOUT_CYCLES,
  localparam int NP_L = NUM_CIMS_P * PARAMS_PER_CIM_P,
  localparam int AW   = clog2_min1(NP_L),
  localparam int CW   = clog2_min1(NUM_CIMS_P),
  localparam int WW   = clog2_min1(PARAMS_PER_CIM_P)
) (
  input  logic                 clk,
  input  logic                 rst_n,   // active-high despite the name
  input  logic                 start_param_load,
  input  logic                 all_cims_ready,
  input  logic                 ext_mem_data_valid,
  input  logic [N_STORAGE-1:0] ext_mem_data,
  output logic                 ext_mem_data_read_pulse,
  output logic [AW-1:0]        ext_mem_addr,
  output logic                 bus_req,
  input  logic                 bus_grant,
  output BusOp_t               bus_op,
  output logic [N-1:0]         bus_data,
  output logic [CW-1:0]        bus_target_or_sender,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output plc_state_t           dbg_state
);

  plc_state_t     state_q, state_d;
  logic [N-1:0]   data_q, data_d;
  logic           clr_all, addr_inc, word_inc, cim_inc;
  logic [AW-1:0]  addr;
  logic [WW-1:0]  word_idx;
  logic [CW-1:0]  cim_idx;
  logic           addr_last, word_last, timeout;

  assign addr_last = (addr == AW'(NP_L - 1));
  assign word_last = (word_idx == WW'(PARAMS_PER_CIM_P - 1));

  // word_idx wraps per CIM; addr wraps after the final word so it idles at 0
  counter #(.W(AW)) u_addr (
    .clk(clk), .rst(rst_n), .clr_i(clr_all | (addr_inc & addr_last)),
    .inc_i(addr_inc), .count_o(addr));
  counter #(.W(WW)) u_word (
    .clk(clk), .rst(rst_n), .clr_i(clr_all | (word_inc & word_last)),
    .inc_i(word_inc), .count_o(word_idx));
  counter #(.W(CW)) u_cim (
    .clk(clk), .rst(rst_n), .clr_i(clr_all),
    .inc_i(cim_inc), .count_o(cim_idx));

`ifdef PARAM_LOAD_TIMEOUT_EN
  localparam int TW = clog2_min1(TIMEOUT_CYCLES_P);
  logic [TW-1:0] wd_cnt;
  logic          error_q;

  // Cleared while issuing the read, so the first WAIT_DATA cycle sees 0
  counter #(.W(TW)) u_watchdog (
    .clk(clk), .rst(rst_n), .clr_i(state_q == S_REQ),
    .inc_i(state_q == S_WAIT_DATA), .count_o(wd_cnt));

  assign timeout = (state_q == S_WAIT_DATA) && !ext_mem_data_valid &&
                   (wd_cnt == TW'(TIMEOUT_CYCLES_P - 1));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)        error_q <= 1'b0;
    else if (clr_all) error_q <= 1'b0;
    else if (timeout) error_q <= 1'b1;
  end
  assign error = error_q;
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  always_comb begin
    state_d                 = state_q;
    data_d                  = data_q;
    clr_all                 = 1'b0;
    addr_inc                = 1'b0;
    word_inc                = 1'b0;
    cim_inc                 = 1'b0;
    ext_mem_data_read_pulse = 1'b0;
    bus_req                 = 1'b0;
    bus_op                  = NOP;
    bus_data                = '0;
    bus_target_or_sender    = '0;
    busy                    = 1'b1;
    done                    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start_param_load) begin
          clr_all = 1'b1;
          state_d = S_WAIT_CIMS;
        end
      end
      S_WAIT_CIMS: if (all_cims_ready) state_d = S_START_CIM;
      S_START_CIM: begin
        bus_req = 1'b1;
        if (bus_grant) begin
          bus_op               = PARAM_STREAM_START_OP;
          bus_target_or_sender = cim_idx;
          bus_data             = N'(PARAMS_PER_CIM_P);
          state_d              = S_REQ;
        end
      end
      S_REQ: begin
        ext_mem_data_read_pulse = 1'b1;
        state_d                 = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (ext_mem_data_valid) begin
          data_d  = {{(N - N_STORAGE){ext_mem_data[N_STORAGE-1]}}, ext_mem_data};
          state_d = S_SEND;
        end else if (timeout) begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        bus_req = 1'b1;
        if (bus_grant) begin
          bus_op               = PARAM_STREAM_OP;
          bus_target_or_sender = cim_idx;
          bus_data             = data_q;
          addr_inc             = 1'b1;
          word_inc             = 1'b1;
          if (addr_last) begin
            state_d = S_DONE;
          end else if (word_last) begin
            cim_inc = 1'b1;
            state_d = S_START_CIM;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign ext_mem_addr = addr;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_param_load_ctrl.sv
// Directed + randomized bench for param_load_ctrl with a memory/bus reference model.
module tb_param_load_ctrl;
  import param_load_ctrl_pkg::*;

  localparam int NC  = 2;
  localparam int PPC = 3;
  localparam int NP  = NC * PPC;
  localparam int TO  = 8;
  localparam int AW  = clog2_min1(NP);
  localparam int CW  = clog2_min1(NC);
  localparam int XW  = 2 + CW + N;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic                 start_param_load, all_cims_ready, ext_mem_data_valid, bus_grant;
  logic [N_STORAGE-1:0] ext_mem_data;
  logic                 ext_mem_data_read_pulse, bus_req, busy, done, error;
  logic [AW-1:0]        ext_mem_addr;
  BusOp_t               bus_op;
  logic [N-1:0]         bus_data;
  logic [CW-1:0]        bus_target_or_sender;
  plc_state_t           dbg_state;

  param_load_ctrl #(.NUM_CIMS_P(NC), .PARAMS_PER_CIM_P(PPC), .TIMEOUT_CYCLES_P(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start_param_load(start_param_load),
    .all_cims_ready(all_cims_ready), .ext_mem_data_valid(ext_mem_data_valid),
    .ext_mem_data(ext_mem_data), .ext_mem_data_read_pulse(ext_mem_data_read_pulse),
    .ext_mem_addr(ext_mem_addr), .bus_req(bus_req), .bus_grant(bus_grant),
    .bus_op(bus_op), .bus_data(bus_data), .bus_target_or_sender(bus_target_or_sender),
    .busy(busy), .done(done), .error(error), .dbg_state(dbg_state));

  // scoreboard and model state
  int checks = 0;
  int errors = 0;
  logic [XW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [N_STORAGE-1:0] mem [NP];
  logic [N-1:0] got_data [NP];
  int  lat = 2;
  bit  lat_rand = 0;
  int  lat_left = -1;
  logic [AW-1:0] pend_addr = '0;
  bit  no_resp = 0;
  int  grant_mode = 0;
  int  hold_left = 0;
  bit  ready_rand = 0;
  bit  word_pending = 0;
  bit  start_req = 0;
  bit  spurious = 0;
  int  done_cnt = 0;
  int  reads = 0;
  int  stream_idx = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] sext(input logic [N_STORAGE-1:0] w);
    int v;
    v = $signed(w);
    return v[N-1:0];
  endfunction

  // reference: every CIM gets a START with its word count, then its words in address order
  task automatic build_expect();
    exp_q.delete();
    exp_addr_q.delete();
    for (int a = 0; a < NP; a++) begin
      if (a % PPC == 0) exp_q.push_back({PARAM_STREAM_START_OP, CW'(a / PPC), N'(PPC)});
      exp_q.push_back({PARAM_STREAM_OP, CW'(a / PPC), sext(mem[a])});
      exp_addr_q.push_back(AW'(a));
    end
  endtask

  task automatic fill_mem();
    for (int a = 0; a < NP; a++) begin
      mem[a] = N_STORAGE'($urandom);
      got_data[a] = '0;
    end
  endtask

  // driver + monitor: drive inputs at negedge, sample 1 time unit later
  task automatic cycle();
    bit held;
    logic [XW-1:0] got;
    held = 0;
    @(negedge clk);
    start_param_load   = start_req;
    start_req          = 0;
    all_cims_ready     = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    ext_mem_data_valid = 1'b0;
    ext_mem_data       = N_STORAGE'($urandom);
    if (spurious) begin
      ext_mem_data_valid = 1'b1;
      spurious = 0;
    end
    if (lat_left > 0) begin
      lat_left--;
      if (lat_left == 0) begin
        ext_mem_data_valid = 1'b1;
        ext_mem_data       = mem[pend_addr];
        lat_left           = -1;
        word_pending       = 1;
      end
    end
    if (hold_left > 0 && word_pending && bus_req) begin
      bus_grant = 1'b0;
      hold_left--;
      held = 1;
    end else begin
      case (grant_mode)
        0:       bus_grant = 1'b1;
        1:       bus_grant = 1'($urandom_range(0, 1));
        default: bus_grant = 1'b0;
      endcase
    end
    #1;
    if (held) begin
      check("hold_req", bus_req, 1);
      check("hold_nop", bus_op, NOP);
    end
    if (ext_mem_data_read_pulse) begin
      reads++;
      check("rd_busy", busy, 1);
      if (exp_addr_q.size() == 0) check("rd_extra", exp_addr_q.size(), 1);
      else check("rd_addr", ext_mem_addr, exp_addr_q.pop_front());
      pend_addr = ext_mem_addr;
      if (!no_resp) lat_left = lat_rand ? $urandom_range(1, 4) : lat;
    end
    if (bus_op != NOP) begin
      check("op_busy", busy, 1);
      check("op_req", bus_req, 1);
      got = {bus_op, bus_target_or_sender, bus_data};
      if (exp_q.size() == 0) check("bus_extra", exp_q.size(), 1);
      else check("bus_xfer", got, exp_q.pop_front());
      if (bus_op == PARAM_STREAM_OP) begin
        word_pending = 0;
        if (stream_idx < NP) got_data[stream_idx] = bus_data;
        stream_idx++;
      end
    end else begin
      check("nop_data", bus_data, 0);
      check("nop_tgt", bus_target_or_sender, 0);
    end
    if (done) begin
      done_cnt++;
      check("done_busy", busy, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pulse"}, ext_mem_data_read_pulse, 0);
    check({tag, "_addr"}, ext_mem_addr, 0);
    check({tag, "_req"}, bus_req, 0);
    check({tag, "_op"}, bus_op, NOP);
    check({tag, "_data"}, bus_data, 0);
    check({tag, "_tgt"}, bus_target_or_sender, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, error, 0);
  endtask

  task automatic start_load();
    build_expect();
    done_cnt = 0;
    stream_idx = 0;
    word_pending = 0;
    lat_left = -1;
    start_req = 1;
    cycle();
    check("busy_at_start", busy, 0);
    cycle();
    check("busy_after_start", busy, 1);
  endtask

  task automatic run_to_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_done_seen"}, done_cnt, 1);
    check({tag, "_bus_drained"}, exp_q.size(), 0);
    check({tag, "_addr_drained"}, exp_addr_q.size(), 0);
    cycle();
    check({tag, "_idle_after"}, busy, 0);
    check({tag, "_done_once"}, done_cnt, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, observed=hang expected=finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int since, n, r0;
    start_param_load = 0; all_cims_ready = 0; ext_mem_data_valid = 0;
    ext_mem_data = '0; bus_grant = 0;

    // reset state
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("rst");
    rst_n = 1'b0;

    // full load, fixed latency 2, grant always, sign-extension vectors
    fill_mem();
    mem[0] = 16'h8001;
    mem[1] = 16'h7FFF;
    start_load();
    run_to_done("basic", 200);
    check("sext_neg", got_data[0], 22'h3F8001);
    check("sext_pos", got_data[1], 22'h007FFF);

    // spurious valid in IDLE, random grant/latency/ready, 5-cycle grant hold, restart attempt
    spurious = 1;
    r0 = reads;
    cycle();
    check("spur_busy", busy, 0);
    check("spur_no_read", reads, r0);
    fill_mem();
    lat_rand = 1; grant_mode = 1; ready_rand = 1; hold_left = 5;
    start_load();
    repeat (10) cycle();
    start_req = 1;
    run_to_done("random", 600);
    check("hold_consumed", hold_left, 0);
    for (int a = 0; a < NP; a++) check("rand_word", got_data[a], sext(mem[a]));

    // reset at word 4, then fresh load from address 0
    lat_rand = 0; grant_mode = 0; ready_rand = 0; lat = 2;
    fill_mem();
    r0 = reads;
    start_load();
    n = 0;
    while (reads < r0 + 4 && n < 100) begin
      cycle();
      n++;
    end
    check("rst_reached_word4", reads, r0 + 4);
    @(negedge clk);
    ext_mem_data_valid = 1'b0;
    rst_n = 1'b1;
    #1 check_reset_outputs("midrst");
    lat_left = -1;
    word_pending = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    fill_mem();
    start_load();
    run_to_done("after_rst", 200);

`ifdef PARAM_LOAD_TIMEOUT_EN
    // memory never answers: watchdog fires after TO WAIT_DATA cycles
    no_resp = 1;
    start_load();
    since = -1;
    n = 0;
    while (error !== 1'b1 && n < 60) begin
      cycle();
      if (ext_mem_data_read_pulse) since = 0;
      else if (since >= 0) since++;
      n++;
    end
    check("to_error", error, 1);
    check("to_latency", since, TO + 1);
    check("to_idle", busy, 0);
    check("to_no_done", done_cnt, 0);
    cycle();
    check("to_sticky", error, 1);
    no_resp = 0;
    start_load();
    check("to_err_cleared", error, 0);
    run_to_done("after_to", 200);
`else
    since = 0;
    check("err_tied", error, since);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
